mastermind_avaliador: RTL

- Reader/consumer side of the guess register in the mastermind datapath.
- The button-driven registrador FSM writes guess slots; this block reads a completed guess and the stored secret, then scores them.
- Scoring is sequential: exact-position matches ("pretos") and right-colour/wrong-position matches ("brancos").
- Result goes to the display/game-control FSM with a one-cycle done pulse.

---
 rtl/mastermind_pkg.sv | 38 +++
 rtl/mastermind_avaliador_contador_cor.sv | 30 +++
 rtl/mastermind_avaliador.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/mastermind_pkg.sv
// Shared definitions for the mastermind datapath: default code geometry,
// FSM state encoding for the evaluator, and a slot-extract helper that
// follows the packing rule (slot i = bits [i*COR_W +: COR_W]).
package mastermind_pkg;

  // Default code geometry.
  localparam int N_POS_DEF = 4;
  localparam int COR_W_DEF = 3;

  // Counter width able to hold 0..N_POS for the default geometry.
  localparam int CNT_W = $clog2(N_POS_DEF + 1);

  // Evaluator FSM encoding.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_PRETOS = 2'd1;
  localparam logic [1:0] ST_CORES  = 2'd2;
  localparam logic [1:0] ST_FIM    = 2'd3;

  // Widest code / colour the slot helper handles; callers zero-extend into it.
  localparam int CODE_MAX_W = 64;
  localparam int SLOT_MAX_W = 8;

  // Returns slot idx of a packed code whose colours are cor_w bits wide.
  // Result is zero-extended to SLOT_MAX_W so two extracts compare directly.
  function automatic logic [SLOT_MAX_W-1:0] slot_get(
    input logic [CODE_MAX_W-1:0] code,
    input int unsigned           idx,
    input int unsigned           cor_w
  );
    logic [CODE_MAX_W-1:0] shifted;
    logic [CODE_MAX_W-1:0] mask;
    shifted = code >> (idx * cor_w);
    mask    = (CODE_MAX_W'(1) << cor_w) - CODE_MAX_W'(1);
    shifted = shifted & mask;
    return shifted[SLOT_MAX_W-1:0];
  endfunction

endpackage

// File: rtl/mastermind_avaliador_contador_cor.sv
// contador_cor: counts how many slots of a packed code hold a given colour.
// Purely combinational; the evaluator uses one instance per code.
module contador_cor
  import mastermind_pkg::*;
#(
  parameter int N_POS = N_POS_DEF,
  parameter int COR_W = COR_W_DEF,
  parameter int CNT_W = $clog2(N_POS_DEF + 1)
) (
  input  logic [N_POS*COR_W-1:0] codigo,
  input  logic [COR_W-1:0]       cor,
  output logic [CNT_W-1:0]       contagem
);

  logic [N_POS-1:0] igual;

  // One comparator per slot.
  for (genvar gi = 0; gi < N_POS; gi++) begin : g_cmp
    assign igual[gi] = (codigo[gi*COR_W +: COR_W] == cor);
  end

  // Population count of the slot matches.
  always_comb begin
    contagem = '0;
    for (int i = 0; i < N_POS; i++) begin
      contagem = contagem + CNT_W'(igual[i]);
    end
  end

endmodule

// File: rtl/mastermind_avaliador.sv
// mastermind_avaliador: scores a latched guess against a latched secret.
// Sequence: IDLE -> PRETOS (N_POS cycles, exact matches) -> CORES
// (2^COR_W cycles, per-colour min of occurrences) -> FIM (one-cycle pronto).
// brancos = total colour matches - pretos.
// Optional build macro AVALIADOR_ATALHO_EN: a fully correct guess skips
// CORES and goes straight from PRETOS to FIM with brancos = 0.
module mastermind_avaliador
  import mastermind_pkg::*;
#(
  parameter int N_POS = N_POS_DEF,
  parameter int COR_W = COR_W_DEF
) (
  input  logic                                 CLK,
  input  logic                                 RST_n,
  input  logic                                 inicio,
  input  logic [N_POS*COR_W-1:0]               segredo,
  input  logic [N_POS*COR_W-1:0]               tentativa,
  output logic                                 ocupado,
  output logic                                 pronto,
  output logic [$clog2(N_POS+1)-1:0]           pretos,
  output logic [$clog2(N_POS+1)-1:0]           brancos,
  output logic                                 acertou
);

  // Width of every count (0..N_POS).
  localparam int CNT_BITS = $clog2(N_POS + 1);
  // idx walks slots in PRETOS and colours in CORES; size for the larger.
  localparam int IDX_W    = (COR_W > $clog2(N_POS)) ? COR_W : $clog2(N_POS);
  localparam int CODE_W   = N_POS * COR_W;
  localparam int N_COR    = 1 << COR_W;

  logic [1:0]          state_reg;
  logic [CODE_W-1:0]   seg_reg;
  logic [CODE_W-1:0]   tent_reg;
  logic [IDX_W-1:0]    idx_reg;
  logic [CNT_BITS-1:0] pretos_acc_reg;
  logic [CNT_BITS-1:0] soma_acc_reg;

  logic                slot_igual;
  logic [CNT_BITS-1:0] pretos_final;
  logic [COR_W-1:0]    cor_atual;
  logic [CNT_BITS-1:0] cnt_seg;
  logic [CNT_BITS-1:0] cnt_tent;
  logic [CNT_BITS-1:0] min_cor;
  logic [CNT_BITS-1:0] soma_final;
  logic                idx_ultima_pos;
  logic                idx_ultima_cor;

  // Exact-position comparison for the slot currently indexed.
  always_comb begin
    slot_igual = (slot_get(CODE_MAX_W'(seg_reg), 32'(idx_reg), COR_W) ==
                  slot_get(CODE_MAX_W'(tent_reg), 32'(idx_reg), COR_W));
  end

  // Per-colour occurrence counts for both latched codes.
  assign cor_atual = idx_reg[COR_W-1:0];

  contador_cor #(
    .N_POS (N_POS),
    .COR_W (COR_W),
    .CNT_W (CNT_BITS)
  ) u_conta_segredo (
    .codigo   (seg_reg),
    .cor      (cor_atual),
    .contagem (cnt_seg)
  );

  contador_cor #(
    .N_POS (N_POS),
    .COR_W (COR_W),
    .CNT_W (CNT_BITS)
  ) u_conta_tentativa (
    .codigo   (tent_reg),
    .cor      (cor_atual),
    .contagem (cnt_tent)
  );

  // Accumulator next values and end-of-phase flags.
  always_comb begin
    pretos_final   = pretos_acc_reg + CNT_BITS'(slot_igual);
    min_cor        = (cnt_seg < cnt_tent) ? cnt_seg : cnt_tent;
    soma_final     = soma_acc_reg + min_cor;
    idx_ultima_pos = (idx_reg == IDX_W'(N_POS - 1));
    idx_ultima_cor = (idx_reg == IDX_W'(N_COR - 1));
  end

  // Evaluation FSM with registered result outputs.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_reg      <= ST_IDLE;
      seg_reg        <= '0;
      tent_reg       <= '0;
      idx_reg        <= '0;
      pretos_acc_reg <= '0;
      soma_acc_reg   <= '0;
      ocupado        <= 1'b0;
      pronto         <= 1'b0;
      pretos         <= '0;
      brancos        <= '0;
      acertou        <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (inicio) begin
            seg_reg        <= segredo;
            tent_reg       <= tentativa;
            pretos_acc_reg <= '0;
            soma_acc_reg   <= '0;
            idx_reg        <= '0;
            ocupado        <= 1'b1;
            state_reg      <= ST_PRETOS;
          end
        end

        ST_PRETOS: begin
          pretos_acc_reg <= pretos_final;
          if (idx_ultima_pos) begin
            idx_reg <= '0;
`ifdef AVALIADOR_ATALHO_EN
            // A perfect guess cannot have colour-only matches, so skip CORES.
            if (pretos_final == CNT_BITS'(N_POS)) begin
              pretos    <= pretos_final;
              brancos   <= '0;
              acertou   <= 1'b1;
              pronto    <= 1'b1;
              state_reg <= ST_FIM;
            end else begin
              state_reg <= ST_CORES;
            end
`else
            state_reg <= ST_CORES;
`endif
          end else begin
            idx_reg <= idx_reg + IDX_W'(1);
          end
        end

        ST_CORES: begin
          soma_acc_reg <= soma_final;
          if (idx_ultima_cor) begin
            // Colour sum always includes every exact match, so no underflow.
            pretos    <= pretos_acc_reg;
            brancos   <= soma_final - pretos_acc_reg;
            acertou   <= (pretos_acc_reg == CNT_BITS'(N_POS));
            pronto    <= 1'b1;
            idx_reg   <= '0;
            state_reg <= ST_FIM;
          end else begin
            idx_reg <= idx_reg + IDX_W'(1);
          end
        end

        ST_FIM: begin
          pronto    <= 1'b0;
          ocupado   <= 1'b0;
          state_reg <= ST_IDLE;
        end

        default: begin
          pronto    <= 1'b0;
          ocupado   <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
